// File: rtl/fd_queue.sv
// rtl/fd_queue.sv - parametrised fetch/decode pipeline buffer with flush squash
//
// Holds up to DEPTH {pc, instruction} pairs between the fetch and decode stages.
// Ports:
//   clk       in   rising-edge clock
//   rstd      in   asynchronous active-high reset
//   flush     in   FLUSH_W squash vector, any set bit empties the buffer
//   in_valid  in   fetch presents pc_in/ins_in
//   in_ready  out  buffer can accept an entry (registered state only)
//   pc_in     in   fetched pc
//   ins_in    in   fetched instruction
//   out_valid out  head entry valid
//   out_ready in   decode consumes the head
//   pc_out    out  head pc, 0 when empty
//   ins_out   out  head instruction, NOP when empty
//   count     out  number of valid entries
module fd_queue #(
    parameter int              PC_W    = 32,
    parameter int              INS_W   = 32,
    parameter int              DEPTH   = 4,
    parameter int              FLUSH_W = 3,
    parameter logic [INS_W-1:0] NOP    = 32'hdc000000
) (
    input  logic                   clk,
    input  logic                   rstd,
    input  logic [FLUSH_W-1:0]     flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        pc_in,
    input  logic [INS_W-1:0]       ins_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        pc_out,
    output logic [INS_W-1:0]       ins_out,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [INS_W-1:0] ins_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic flush_any;
    logic push;
    logic pop;

    // Handshake flags come only from registered count, so no input reaches an output.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);

    assign flush_any = |flush;
    assign push      = in_valid & in_ready & ~flush_any;
    assign pop       = out_valid & out_ready & ~flush_any;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_any) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; empty-state outputs are forced below instead.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= pc_in;
            ins_mem[wr_ptr_q] <= ins_in;
        end
    end

    assign pc_out  = out_valid ? pc_mem[rd_ptr_q]  : '0;
    assign ins_out = out_valid ? ins_mem[rd_ptr_q] : NOP;
    assign count   = count_q;

endmodule

// File: tb/tb_fd_queue.sv
// tb/tb_fd_queue.sv - scoreboard testbench for fd_queue
module tb_fd_queue;

    localparam logic [31:0] NOP_V = 32'hdc000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk;
    logic        rstd;
    logic [2:0]  flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_in;
    logic [31:0] ins_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] ins_out;
    logic [2:0]  count;

    int   checks;
    int   failures;
    ent_t sb[$];
    logic last_acc;

    fd_queue dut (
        .clk       (clk),
        .rstd      (rstd),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc_in     (pc_in),
        .ins_in    (ins_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_out    (pc_out),
        .ins_out   (ins_out),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every head the decode stage consumes must match the scoreboard front.
    always @(negedge clk) begin
        if (!rstd && out_valid && out_ready && flush == 3'b000) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=pc %0h expected=none", pc_out);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("head_pc", 64'(pc_out), 64'(e.pc));
                chk("head_ins", 64'(ins_out), 64'(e.ins));
            end
        end
    end

    // Called at posedge+1: apply inputs, record the model at negedge, return at next posedge+1.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic [2:0] fl);
        in_valid  = v;
        pc_in     = pc;
        ins_in    = ins;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        last_acc = in_valid && in_ready && (flush == 3'b000);
        if (last_acc) sb.push_back('{pc: pc_in, ins: ins_in});
        if (flush != 3'b000) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int guard;
        checks   = 0;
        failures = 0;

        // 1. Reset with random inputs
        rstd      = 1'b1;
        flush     = 3'b000;
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        pc_in     = $urandom;
        ins_in    = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ins_out", 64'(ins_out), 64'(NOP_V));
        chk("rst_pc_out", 64'(pc_out), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rstd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("idle_out_valid", 64'(out_valid), 64'd0);
            chk("idle_ins_out", 64'(ins_out), 64'(NOP_V));
            chk("idle_count", 64'(count), 64'd0);
        end

        // 2. Fill to full, then a push while full is ignored
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 3'b000);
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h110, 32'hA4, 1'b0, 3'b000);
        chk("full_push_acc", 64'(last_acc), 64'd0);
        chk("full_head_pc", 64'(pc_out), 64'h100);
        chk("full_head_ins", 64'(ins_out), 64'hA0);
        chk("full_count2", 64'(count), 64'd4);

        // 3. Drain with wrap-around; fetch holds data until accepted
        k = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h110 + 32'(4 * k), 32'hA4 + 32'(k), 1'b1, 3'b000);
            if (last_acc) k++;
            chk("drain_count", 64'(count), 64'd3);
        end
        chk("drain_pushed", 64'(k), 64'd5);
        guard = 0;
        while (count != 3'd0 && guard < 20) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 3'b000);
            guard++;
        end
        chk("drain_guard", 64'(guard), 64'd3);
        chk("empty_out_valid", 64'(out_valid), 64'd0);
        chk("empty_ins_nop", 64'(ins_out), 64'(NOP_V));
        chk("empty_pc_zero", 64'(pc_out), 64'd0);

        // 4. Simultaneous push and pop at count=1
        drive(1'b1, 32'h300, 32'hB0, 1'b0, 3'b000);
        chk("one_count", 64'(count), 64'd1);
        chk("one_pc", 64'(pc_out), 64'h300);
        drive(1'b1, 32'h304, 32'hB1, 1'b1, 3'b000);
        chk("pp_count", 64'(count), 64'd1);
        chk("pp_head_pc", 64'(pc_out), 64'h304);
        chk("pp_head_ins", 64'(ins_out), 64'hB1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 3'b000);
        chk("pp_empty", 64'(count), 64'd0);

        // 5. Flush with concurrent push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 3'b000);
        end
        chk("pre_flush_count", 64'(count), 64'd3);
        drive(1'b1, 32'h200, 32'hD0, 1'b1, 3'b010);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_ins_nop", 64'(ins_out), 64'(NOP_V));
        drive(1'b1, 32'h204, 32'hD1, 1'b0, 3'b000);
        chk("post_flush_pc", 64'(pc_out), 64'h204);
        chk("post_flush_ins", 64'(ins_out), 64'hD1);
        chk("post_flush_count", 64'(count), 64'd1);
        for (int i = 0; i < 2; i++) begin
            chk("flush_in_ready", 64'(in_ready), 64'd1);
            drive(1'b1, 32'h208, 32'hD2, 1'b1, 3'b100);
            chk("flush_hold_count", 64'(count), 64'd0);
        end

        // 6. Asynchronous reset between clock edges
        drive(1'b1, 32'h500, 32'hE0, 1'b0, 3'b000);
        drive(1'b1, 32'h504, 32'hE1, 1'b0, 3'b000);
        in_valid = 1'b0;
        chk("pre_arst_count", 64'(count), 64'd2);
        #2;
        rstd = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_ins_nop", 64'(ins_out), 64'(NOP_V));
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_pc_zero", 64'(pc_out), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rstd = 1'b0;
        idle();
        chk("after_arst_in_ready", 64'(in_ready), 64'd1);
        chk("after_arst_count", 64'(count), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
